// File: rtl/irq_arbiter.sv
// External interrupt arbiter: edge-captured pending bits, fixed-priority pick,
// REQ/SERVICE handshake with the CSR unit and a 4-word configuration port.
//
// state   | meaning
// IDLE    | no request outstanding; latch the winner when one exists
// REQ     | meip_o high, waiting for trap-entry acknowledge
// SERVICE | source claimed; waiting for a matching COMPLETE write
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_SRC-1:0]  irq_src_i,
  input  logic              ack_i,
  input  logic              cfg_wen_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [31:0]       cfg_data_i,
  output logic [31:0]       cfg_data_o,
  output logic              meip_o,
  output logic [ID_W-1:0]   irq_id_o
);

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM    = 2'd2;
  localparam logic [1:0] ADDR_COMPLETE = 2'd3;

  if (N_SRC < 1 || N_SRC > 31) begin : g_bad_nsrc
    $error("irq_arbiter: N_SRC must be in 1..31");
  end
  if (N_SRC > (2 ** ID_W)) begin : g_bad_idw
    $error("irq_arbiter: ID_W too narrow for N_SRC");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_SRC-1:0]  sync_q1, sync_q2, sync_q3;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  enable_q;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  id_mask;
  logic [N_SRC-1:0]  req_vec;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              cur_pending;
  logic              cur_enable;
  logic              claim_clr;
  logic              complete_hit;
  logic [31:0]       rd_data;
  logic              unused_cfg;

  assign unused_cfg = ^cfg_data_i;

  // Two synchronizer stages, the third stage only serves edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      sync_q3 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~sync_q3;

  assign req_vec = pending_q & enable_q;
  assign any_req = |req_vec;

  always_comb begin
    winner = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_vec[k]) winner = ID_W'(k);
    end
  end

  // Mask form avoids indexing past N_SRC when ID_W is wider than needed.
  assign id_mask     = N_SRC'(1) << id_q;
  assign cur_pending = |(pending_q & id_mask);
  assign cur_enable  = |(enable_q & id_mask);

  assign complete_hit = cfg_wen_i && (cfg_addr_i == ADDR_COMPLETE) &&
                        (cfg_data_i[ID_W-1:0] == id_q);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    claim_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d    = winner;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_i) begin
          claim_clr = 1'b1;
          state_d   = S_SERVICE;
        end else if (!cur_enable || !cur_pending) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (complete_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh edge on the claimed source wins over the claim clear.
  always_comb begin
    pending_d = pending_q;
    if (claim_clr) pending_d = pending_d & ~id_mask;
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enable_q <= '0;
    end else if (cfg_wen_i && (cfg_addr_i == ADDR_ENABLE)) begin
      enable_q <= cfg_data_i[N_SRC-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (cfg_addr_i)
      ADDR_ENABLE:  rd_data = 32'(enable_q);
      ADDR_PENDING: rd_data = 32'(pending_q);
      ADDR_CLAIM: begin
        if (state_q == S_SERVICE) begin
          rd_data[ID_W-1:0] = id_q;
          rd_data[31]       = 1'b1;
        end
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_data_o <= '0;
    end else begin
      cfg_data_o <= rd_data;
    end
  end

  assign meip_o   = (state_q == S_REQ);
  assign irq_id_o = id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: stimulus queues expected read data and
// expected request IDs; monitors compare when the DUT presents them.
module tb_irq_arbiter;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [N_SRC-1:0]  irq_src_i = '0;
  logic              ack_i = 1'b0;
  logic              cfg_wen_i = 1'b0;
  logic [1:0]        cfg_addr_i = '0;
  logic [31:0]       cfg_data_i = '0;
  logic [31:0]       cfg_data_o;
  logic              meip_o;
  logic [ID_W-1:0]   irq_id_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [31:0] req_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_v = 1'b0;
  logic        meip_prev = 1'b0;

  irq_arbiter #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .irq_src_i  (irq_src_i),
    .ack_i      (ack_i),
    .cfg_wen_i  (cfg_wen_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .cfg_data_o (cfg_data_o),
    .meip_o     (meip_o),
    .irq_id_o   (irq_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read monitor: the DUT presents read data one edge after the address.
  always @(posedge clk_i) rd_v <= rd_issue;

  always @(negedge clk_i) begin
    if (rd_v) begin
      if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
      else check("cfg_read", cfg_data_o, rd_q.pop_front());
    end
  end

  // Request monitor: every rising meip_o must match the next expected ID.
  always @(negedge clk_i) begin
    if (meip_o && !meip_prev) begin
      if (req_q.size() == 0) check("unexpected_req", 32'(irq_id_o), 32'hFFFF_FFFF);
      else check("req_id", 32'(irq_id_o), req_q.pop_front());
    end
    meip_prev <= meip_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_wen_i  = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = data;
    @(negedge clk_i);
    cfg_wen_i  = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr_i = addr;
    rd_q.push_back(exp);
    rd_issue = 1'b1;
    @(negedge clk_i);
    rd_issue = 1'b0;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    check("meip_after_ack", 32'(meip_o), 32'd0);
  endtask

  task automatic wait_meip(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (meip_o) break;
      @(negedge clk_i);
    end
    check(name, 32'(meip_o), 32'd1);
  endtask

  task automatic pulse_src(input logic [N_SRC-1:0] mask);
    irq_src_i = irq_src_i | mask;
    tick(2);
    irq_src_i = irq_src_i & ~mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / idle
    tick(3);
    check("rst_meip", 32'(meip_o), 32'd0);
    check("rst_id", 32'(irq_id_o), 32'd0);
    check("rst_rdata", cfg_data_o, 32'd0);
    reset_i = 1'b0;
    cfg_read(2'd0, 32'd0);
    cfg_read(2'd1, 32'd0);
    cfg_read(2'd2, 32'd0);

    cfg_write(2'd0, 32'h01);
    req_q.push_back(32'd0);
    irq_src_i[0] = 1'b1;
    tick(2);
    irq_src_i[0] = 1'b0;
    tick(1);
    check("lat_e3_meip", 32'(meip_o), 32'd0);
    tick(1);
    check("lat_e4_meip", 32'(meip_o), 32'd1);
    check("lat_e4_id", 32'(irq_id_o), 32'd0);
    cfg_read(2'd1, 32'h01);
    do_ack();
    cfg_read(2'd1, 32'h00);
    cfg_read(2'd2, 32'h8000_0000);
    cfg_write(2'd3, 32'd0);
    cfg_read(2'd2, 32'h0);

    // Priority
    cfg_write(2'd0, 32'hFF);
    req_q.push_back(32'd2);
    pulse_src(8'h24);
    wait_meip("prio_req", 10);
    check("prio_id", 32'(irq_id_o), 32'd2);
    cfg_read(2'd2, 32'h0);
    cfg_read(2'd1, 32'h24);
    do_ack();
    cfg_read(2'd2, 32'h8000_0002);
    cfg_read(2'd1, 32'h20);
    req_q.push_back(32'd5);
    cfg_write(2'd3, 32'd2);
    check("prio_idle_after_complete", 32'(meip_o), 32'd0);
    tick(1);
    check("prio_req5", 32'(meip_o), 32'd1);
    check("prio_id5", 32'(irq_id_o), 32'd5);
    do_ack();
    cfg_write(2'd3, 32'd5);

    // No preemption / mismatched complete
    req_q.push_back(32'd4);
    pulse_src(8'h10);
    wait_meip("nopre_req", 10);
    pulse_src(8'h01);
    tick(4);
    check("nopre_id", 32'(irq_id_o), 32'd4);
    check("nopre_meip", 32'(meip_o), 32'd1);
    cfg_read(2'd1, 32'h11);
    do_ack();
    cfg_write(2'd3, 32'd1);
    cfg_read(2'd2, 32'h8000_0004);
    check("mismatch_meip", 32'(meip_o), 32'd0);
    req_q.push_back(32'd0);
    cfg_write(2'd3, 32'd4);
    check("complete4_idle", 32'(meip_o), 32'd0);
    tick(1);
    check("req0_meip", 32'(meip_o), 32'd1);
    check("req0_id", 32'(irq_id_o), 32'd0);
    do_ack();
    cfg_write(2'd3, 32'd0);

    // Enable drop
    req_q.push_back(32'd3);
    pulse_src(8'h08);
    wait_meip("endrop_req", 10);
    check("endrop_id", 32'(irq_id_o), 32'd3);
    cfg_write(2'd0, 32'h00);
    tick(1);
    check("endrop_meip", 32'(meip_o), 32'd0);
    cfg_read(2'd1, 32'h08);
    req_q.push_back(32'd3);
    cfg_write(2'd0, 32'hFF);
    wait_meip("reen_req", 10);
    check("reen_id", 32'(irq_id_o), 32'd3);
    do_ack();
    cfg_write(2'd3, 32'd3);

    // Set/clear collision on source 1
    req_q.push_back(32'd1);
    pulse_src(8'h02);
    wait_meip("coll_req", 10);
    tick(4);
    irq_src_i[1] = 1'b1;
    tick(2);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    irq_src_i[1] = 1'b0;
    check("coll_meip", 32'(meip_o), 32'd0);
    cfg_read(2'd1, 32'h02);
    cfg_read(2'd2, 32'h8000_0001);
    req_q.push_back(32'd1);
    cfg_write(2'd3, 32'd1);
    check("coll_idle", 32'(meip_o), 32'd0);
    tick(1);
    check("coll_rereq", 32'(meip_o), 32'd1);
    check("coll_id", 32'(irq_id_o), 32'd1);
    do_ack();
    cfg_write(2'd3, 32'd1);

    // Reset mid-service
    req_q.push_back(32'd0);
    pulse_src(8'h41);
    wait_meip("rst_req", 10);
    check("rst_req_id", 32'(irq_id_o), 32'd0);
    do_ack();
    cfg_read(2'd1, 32'h40);
    irq_src_i[0] = 1'b1;
    reset_i = 1'b1;
    #1;
    check("midrst_meip", 32'(meip_o), 32'd0);
    check("midrst_rdata", cfg_data_o, 32'd0);
    check("midrst_id", 32'(irq_id_o), 32'd0);
    tick(2);
    reset_i = 1'b0;
    req_q.push_back(32'd0);
    cfg_read(2'd1, 32'h00);
    cfg_write(2'd0, 32'h01);
    wait_meip("post_rst_req", 10);
    check("post_rst_id", 32'(irq_id_o), 32'd0);
    cfg_read(2'd1, 32'h01);
    do_ack();
    tick(6);
    cfg_read(2'd1, 32'h00);
    check("post_rst_single", 32'(meip_o), 32'd0);
    cfg_write(2'd3, 32'd0);
    irq_src_i[0] = 1'b0;
    tick(5);

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("req_q_drained", req_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

External interrupt controller that feeds the machine-mode CSR block. It collects up to `N_SRC` edge-triggered interrupt sources and latches each one as pending. It picks the enabled pending source with the highest priority, raises `meip_o` until the core acknowledges entry into the trap, and then holds off further requests until software writes the matching completion. Software reads and writes its enable, pending, claim and complete registers through a small word-addressed configuration port.

## Interface
- `N_SRC`, default 8: number of interrupt sources, range 1..31.
- `ID_W`, default 3: width of the source ID. Required: `N_SRC <= 2**ID_W`.
- `clk_i`  in  1  system clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `irq_src_i`  in  N_SRC  raw source lines, asynchronous. A rising edge is an event.
- `ack_i`  in  1  trap-entry acknowledge from the CSR unit, one-cycle pulse.
- `cfg_wen_i`  in  1  active-high write strobe.
- `cfg_addr_i`  in  2  register select.
- `cfg_data_i`  in  32  write data.
- `cfg_data_o`  out  32  registered read data.
- `meip_o`  out  1  machine external interrupt request, level.
- `irq_id_o`  out  ID_W  ID of the arbitrated or claimed source.

## Operation
Register map (`cfg_addr_i`):
- 0 ENABLE: read/write. Bits [N_SRC-1:0] used; upper bits read 0.
- 1 PENDING: read-only. Writes are ignored.
- 2 CLAIM: read-only. Returns `{valid, id}`: bit 31 = 1 in SERVICE, bits [ID_W-1:0] = claimed ID. Reads all-zero outside SERVICE.
- 3 COMPLETE: write-only, reads 0. Writing `cfg_data_i[ID_W-1:0]` equal to the claimed ID while in SERVICE ends service.

Source capture:
- Each `irq_src_i` bit passes through a 2-FF synchronizer, then a third FF for edge detection.
- A synchronized rising edge sets `pending[k]`.
- If a set and a claim-clear hit the same bit in the same cycle, the set wins and the bit stays 1.

Arbitration:
- Fixed priority: lowest index is highest priority.
- `winner` = lowest k with `pending[k] & enable[k]`.

State machine (reset state IDLE):
- IDLE: `meip_o` = 0. If any enabled source is pending, latch `winner` into `irq_id_o` and go to REQ.
- REQ: `meip_o` = 1.
  - If `ack_i`: clear `pending[irq_id_o]` and go to SERVICE.
  - Else if `enable[irq_id_o]` or `pending[irq_id_o]` is 0: go to IDLE and drop the request.
  - A higher-priority source arriving during REQ does not preempt; `irq_id_o` stays stable.
- SERVICE: `meip_o` = 0.
  - A COMPLETE write with the matching ID goes to IDLE.
  - A COMPLETE write with a mismatched ID is ignored.
  - `ack_i` is ignored.
- `ack_i` outside REQ has no effect.

## Timing
- Reset values (all outputs and registers 0): `meip_o` = 0, `irq_id_o` = 0, `cfg_data_o` = 0, ENABLE = 0, PENDING = 0, synchronizers = 0, state = IDLE.
- Reset asserted mid-operation aborts any REQ or SERVICE and discards all pending events.
- A source that is already high when reset is released counts as one rising edge.
- Latency, source rise to pending:
  - `irq_src_i` rises before edge E1.
  - `pending[k]` is 1 after edge E3.
  - State = REQ and `meip_o` = 1 after edge E4, provided the source is enabled and the FSM is in IDLE.
- `meip_o` and `irq_id_o` are decoded from registered state only; no combinational path from any input.
- Acknowledge: `ack_i` sampled high at edge Ea gives `meip_o` = 0 and `pending[id]` cleared after Ea.
- Config writes take effect at the rising edge where `cfg_wen_i` = 1.
- Config reads:
  - `cfg_data_o` is updated every edge from `cfg_addr_i` (one-cycle read latency).
  - A read and a write in the same cycle return the pre-write value.
- After a COMPLETE write at edge Ec, state = IDLE after Ec. If another enabled source is pending, REQ follows after Ec+1.
- Simultaneous ENABLE write and arbitration in IDLE: arbitration uses the pre-write enable.

## Test plan
- Reset / idle: hold `reset_i` = 1 with all sources low → all outputs 0. Write ENABLE = 0x01, pulse `irq_src_i[0]` → `meip_o` = 1 exactly 4 edges after the rise, `irq_id_o` = 0.
- Priority: ENABLE = 0xFF, raise sources 5 and 2 in the same cycle.
  - Before any `ack_i`, `irq_id_o` = 2 and CLAIM reads 0.
  - After `ack_i`, CLAIM reads 0x8000_0002.
  - COMPLETE = 2 → REQ with `irq_id_o` = 5.
- No preemption / mismatched complete:
  - Source 4 in REQ, then source 0 rises → `irq_id_o` stays 4 until `ack_i`.
  - In SERVICE, COMPLETE = 1 → state unchanged.
  - COMPLETE = 4 → IDLE, then REQ for ID 0.
- Enable drop: in REQ for source 3, write ENABLE = 0 → `meip_o` falls the next edge, PENDING still reads 0x08. Re-enable → REQ again with ID 3.
- Set/clear collision: a new edge on source 1 is timed so that `pending[1]` sets on the same edge `ack_i` claims ID 1 → PENDING bit 1 reads 1, and REQ for ID 1 follows the COMPLETE.
- Reset mid-service: assert `reset_i` in SERVICE → `meip_o` = 0 and PENDING = 0 immediately. Release with `irq_src_i[0]` held high and ENABLE rewritten → one new event is captured.
